// File: rtl/cc_banks_req_ctrl_pkg.sv
// Shared constants and types for the cc_banks request front-end.
package cc_banks_req_ctrl_pkg;

  localparam int CC_BANK_ADDR_W = 13;
  localparam int CC_BANK_DATA_W = 64;
  localparam int CC_RSP_DEPTH   = 3;

  // SoC macro control bundle for single-port SRAM instances.
  typedef struct packed {
    logic [1:0] rtsel;
    logic [1:0] wtsel;
    logic       ls;
    logic       ds;
    logic       sd;
  } mem_ctrl_sasrl_1p_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cc_banks_req_ctrl_if.sv
// Request/response stream bundle between a client and cc_banks_req_ctrl.
interface cc_banks_req_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wmode;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_addr, req_wmode, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wmode, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cc_banks_rsp_fifo.sv
// Small circular response FIFO; the head entry is presented combinationally.
module cc_banks_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr];
  assign count   = count_q;

  // The upstream credit check makes both of these unreachable.
  overflow_chk:  assert property (@(posedge clock) disable iff (reset) !(push && (count_q == FULL_CNT)));
  underflow_chk: assert property (@(posedge clock) disable iff (reset) !(pop && (count_q == '0)));

endmodule

// File: rtl/cc_banks_req_ctrl.sv
// Valid/ready front-end for the cc_banks_0_ext single-port bank with
// credit-throttled reads and a response FIFO for 1-cycle-latency read data.
module cc_banks_req_ctrl
  import cc_banks_req_ctrl_pkg::*;
#(
  parameter int ADDR_W    = CC_BANK_ADDR_W,
  parameter int DATA_W    = CC_BANK_DATA_W,
  parameter int RSP_DEPTH = CC_RSP_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  cc_banks_req_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]  RW0_addr,
  output logic               RW0_en,
  output logic               RW0_wmode,
  output logic [DATA_W-1:0]  RW0_wdata,
  input  logic [DATA_W-1:0]  RW0_rdata,
  input  mem_ctrl_sasrl_1p_t mem_ctrl_sasrl_i,
  output mem_ctrl_sasrl_1p_t mem_ctrl_sasrl_o,
  output logic               busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             rd_pending;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   outstanding;
  logic             accept;
  logic             rd_accept;
  logic             pop;

  // Credits come from registers only, so ready never depends on this cycle's inputs.
  assign outstanding   = {1'b0, count} + (CNT_W + 1)'(rd_pending);
  assign bus.req_ready = (outstanding < (CNT_W + 1)'(RSP_DEPTH));

  assign accept    = bus.req_valid && bus.req_ready;
  assign rd_accept = accept && !bus.req_wmode;

  assign RW0_en    = accept;
  assign RW0_wmode = accept && bus.req_wmode;
  assign RW0_addr  = bus.req_addr;
  assign RW0_wdata = bus.req_wdata;

  assign mem_ctrl_sasrl_o = mem_ctrl_sasrl_i;

  // rd_pending marks the cycle in which the bank presents read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pending <= 1'b0;
    else       rd_pending <= rd_accept;
  end

  assign bus.rsp_valid = (count != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  cc_banks_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pending),
    .push_data (RW0_rdata),
    .pop       (pop),
    .rd_data   (bus.rsp_rdata),
    .count     (count)
  );

  assign busy = rd_pending || (count != '0);

endmodule
